// File: rtl/mem_access_ctrl_if.sv
// Request/response and SRAM strobe bundle between the sequencer and its
// neighbours. The tri-state Data bus stays a plain inout on the sequencer.
interface mem_access_ctrl_if;
  logic        req_rd;
  logic        req_wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] S;
  logic [15:0] rdata;
  logic        done;
  logic        busy;
  logic [15:0] hex_data;
  logic [19:0] ADDR;
  logic        Mem_CE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic        Mem_OE;
  logic        Mem_WE;

  // requester side (ISDU / datapath / board I/O)
  modport master (
    output req_rd, req_wr, addr, wdata, S,
    input  rdata, done, busy, hex_data, ADDR, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  // sequencer side
  modport slave (
    input  req_rd, req_wr, addr, wdata, S,
    output rdata, done, busy, hex_data, ADDR, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory sequencer between MAR/MDR and a 16-bit async SRAM, with a single
// memory-mapped I/O word (switches on read, hex display on write).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for req_rd/req_wr; I/O accesses complete from here
// SETUP   | address (and write data) presented, CE/UB/LB low
// ACCESS  | OE (read) or WE (write) low for WAIT_CYCLES cycles
// DONE    | one-cycle done pulse, strobes released, write data held
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_access_ctrl_if.slave  bus,
  inout  wire  [15:0]       Data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        wr_q, wr_d;
  logic        io_q, io_d;

  logic        req;
  logic        req_io;
  logic        in_sram;
  logic        drive_data;

  assign req    = bus.req_rd | bus.req_wr;
  assign req_io = (bus.addr == IO_ADDR);

  // state and datapath registers; reset aborts any access immediately
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      wr_q    <= wr_d;
      io_q    <= io_d;
    end
  end

  // next-state, request capture, wait counting and read/I/O data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    wr_d    = wr_q;
    io_d    = io_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          // a simultaneous read and write resolves to a read
          wr_d    = bus.req_wr & ~bus.req_rd;
          io_d    = req_io;
          wdata_d = bus.wdata;
          if (req_io) begin
            // I/O address is never forwarded to the SRAM, so addr_q keeps its value
            state_d = S_DONE;
            if (bus.req_rd) rdata_d = bus.S;
            else            hex_d   = bus.wdata;
          end else begin
            addr_d  = bus.addr;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = 4'(WAIT_CYCLES - 1);
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!wr_q) rdata_d = Data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_sram = (state_q == S_SETUP) || (state_q == S_ACCESS);

  // write data is held from SETUP through DONE so it brackets the WE pulse
  assign drive_data = wr_q && !io_q && (state_q != S_IDLE);
  assign Data       = drive_data ? wdata_q : 16'hzzzz;

  assign bus.Mem_CE   = ~in_sram;
  assign bus.Mem_UB   = ~in_sram;
  assign bus.Mem_LB   = ~in_sram;
  assign bus.Mem_OE   = ~((state_q == S_ACCESS) && !wr_q);
  assign bus.Mem_WE   = ~((state_q == S_ACCESS) &&  wr_q);
  assign bus.ADDR     = {4'b0000, addr_q};
  assign bus.rdata    = rdata_q;
  assign bus.hex_data = hex_q;
  assign bus.done     = (state_q == S_DONE);
  assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with an SRAM backing-store model and a
// transaction-level reference model checked on every falling edge.
module tb_mem_access_ctrl;
  localparam int W = 2;

  logic        Clk;
  logic        Reset;
  wire  [15:0] Data;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus),
    .Data  (Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] init_val(logic [7:0] a);
    return {8'hA5, a};
  endfunction

  // SRAM backing store (async SRAM behaviour, 256 words is plenty here)
  logic [15:0] sram_mem [0:255];
  bit          sram_wr  [0:255];
  logic [15:0] sram_q;

  always_comb begin
    sram_q = sram_wr[bus.ADDR[7:0]] ? sram_mem[bus.ADDR[7:0]] : init_val(bus.ADDR[7:0]);
  end

  always @(posedge Clk) begin
    if (!bus.Mem_CE && !bus.Mem_WE) begin
      sram_mem[bus.ADDR[7:0]] <= Data;
      sram_wr[bus.ADDR[7:0]]  <= 1'b1;
    end
  end

  assign Data = (!bus.Mem_CE && !bus.Mem_OE) ? sram_q : 16'hzzzz;

  function automatic logic [15:0] sram_peek(logic [7:0] a);
    return sram_wr[a] ? sram_mem[a] : init_val(a);
  endfunction

  // reference model: one transaction at a time, k = cycle index after the accepting edge
  bit          m_active;
  int          m_k, m_len;
  bit          m_rd, m_io;
  logic [15:0] m_addr, m_wdata, m_rdata, m_hex;
  logic [15:0] m_mem [0:255];
  bit          m_wr  [0:255];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_len    <= 0;
      m_rd     <= 1'b0;
      m_io     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_rdata  <= '0;
      m_hex    <= '0;
    end else if (m_active) begin
      if (!m_io && m_k == W + 1) begin
        if (m_rd) m_rdata <= m_wr[m_addr[7:0]] ? m_mem[m_addr[7:0]] : init_val(m_addr[7:0]);
        else begin
          m_mem[m_addr[7:0]] <= m_wdata;
          m_wr[m_addr[7:0]]  <= 1'b1;
        end
      end
      if (m_k == m_len) m_active <= 1'b0;
      else              m_k      <= m_k + 1;
    end else if (bus.req_rd || bus.req_wr) begin
      m_active <= 1'b1;
      m_k      <= 1;
      m_rd     <= bus.req_rd;
      m_wdata  <= bus.wdata;
      if (bus.addr == 16'hFFFF) begin
        m_io  <= 1'b1;
        m_len <= 1;
        if (bus.req_rd) m_rdata <= bus.S;
        else            m_hex   <= bus.wdata;
      end else begin
        m_io   <= 1'b0;
        m_len  <= W + 2;
        m_addr <= bus.addr;
      end
    end
  end

  // event counters for the directed checks
  int we_cnt = 0, ce_cnt = 0, done_cnt = 0;

  // per-cycle compare of every output against the model
  initial begin
    bit prev_done = 1'b0;
    bit strobe, sram_on, exp_done;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        sram_on  = m_active && !m_io && m_k >= 1 && m_k <= W + 1;
        strobe   = m_active && !m_io && m_k >= 2 && m_k <= W + 1;
        exp_done = m_active && m_k == m_len;
        chk("Mem_CE", bus.Mem_CE, !sram_on);
        chk("Mem_UB", bus.Mem_UB, !sram_on);
        chk("Mem_LB", bus.Mem_LB, !sram_on);
        chk("Mem_OE", bus.Mem_OE, !(strobe && m_rd));
        chk("Mem_WE", bus.Mem_WE, !(strobe && !m_rd));
        chk("done", bus.done, exp_done);
        chk("busy", bus.busy, m_active);
        chk("ADDR", bus.ADDR, {4'h0, m_addr});
        chk("rdata", bus.rdata, m_rdata);
        chk("hex_data", bus.hex_data, m_hex);
        if (m_active && !m_io && !m_rd) chk("data_wr_drive", Data, m_wdata);
        if (!bus.Mem_OE) chk("bus_contention", Data, sram_q);
        chk("oe_we_exclusive", !bus.Mem_OE && !bus.Mem_WE, 1'b0);
        chk("done_consecutive", bus.done && prev_done, 1'b0);
        prev_done = bus.done;
        if (!bus.Mem_WE) we_cnt++;
        if (!bus.Mem_CE) ce_cnt++;
        if (bus.done) done_cnt++;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // issue one request from a falling edge; optionally pulse req_rd at cycle gcyc
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input int gcyc, output int lat);
    bus.req_rd = rd;
    bus.req_wr = wr;
    bus.addr   = a;
    bus.wdata  = d;
    @(posedge Clk);
    @(negedge Clk);
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      if (c == gcyc) begin
        bus.req_rd = 1'b1;
        bus.addr   = 16'h0010;
      end else if (c == gcyc + 1) begin
        bus.req_rd = 1'b0;
        bus.addr   = a;
      end
      @(negedge Clk);
    end
    bus.req_rd = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int lat, we0, ce0, dn0;
    Reset      = 1'b0;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    bus.S      = 16'h1234;

    @(negedge Clk);
    chk("rst_Mem_CE", bus.Mem_CE, 1'b1);
    chk("rst_Mem_OE", bus.Mem_OE, 1'b1);
    chk("rst_Mem_WE", bus.Mem_WE, 1'b1);
    chk("rst_ADDR", bus.ADDR, 20'h0);
    chk("rst_rdata", bus.rdata, 16'h0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_hex", bus.hex_data, 16'h0);
    Reset = 1'b1;
    @(negedge Clk);

    // SRAM write then read back
    we0 = we_cnt;
    do_req(1'b0, 1'b1, 16'h0042, 16'hBEEF, 0, lat);
    chk("wr_latency", lat, 4);
    chk("wr_we_cycles", we_cnt - we0, 2);
    chk("wr_store", sram_peek(8'h42), 16'hBEEF);
    do_req(1'b1, 1'b0, 16'h0042, 16'h0000, 0, lat);
    chk("rd_latency", lat, 4);
    chk("rd_data", bus.rdata, 16'hBEEF);
    chk("rd_addr", bus.ADDR, 20'h00042);

    // I/O read of the switches
    ce0 = ce_cnt;
    do_req(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, lat);
    chk("io_rd_latency", lat, 1);
    chk("io_rd_data", bus.rdata, 16'h1234);
    chk("io_rd_no_ce", ce_cnt - ce0, 0);

    // I/O write to the hex display
    ce0 = ce_cnt;
    do_req(1'b0, 1'b1, 16'hFFFF, 16'h00A5, 0, lat);
    chk("io_wr_latency", lat, 1);
    chk("io_wr_hex", bus.hex_data, 16'h00A5);
    chk("io_wr_no_ce", ce_cnt - ce0, 0);
    chk("io_wr_sram_untouched", sram_peek(8'hFF), 16'hA5FF);

    // read and write together resolve to a read
    we0 = we_cnt;
    do_req(1'b1, 1'b1, 16'h0010, 16'h7777, 0, lat);
    chk("both_latency", lat, 4);
    chk("both_no_we", we_cnt - we0, 0);
    chk("both_mem_unchanged", sram_peek(8'h10), 16'hA510);
    chk("both_rdata", bus.rdata, 16'hA510);

    // request pulsed during ACCESS is ignored
    dn0 = done_cnt;
    do_req(1'b1, 1'b0, 16'h0042, 16'h0000, 2, lat);
    chk("glitch_latency", lat, 4);
    chk("glitch_one_done", done_cnt - dn0, 1);
    chk("glitch_rdata", bus.rdata, 16'hBEEF);
    repeat (3) @(negedge Clk);
    chk("glitch_not_queued", done_cnt - dn0, 1);

    // reset in the middle of a write aborts it
    bus.req_wr = 1'b1;
    bus.addr   = 16'h0050;
    bus.wdata  = 16'h1111;
    @(posedge Clk);
    @(negedge Clk);
    bus.req_wr = 1'b0;
    @(negedge Clk);
    chk("abort_we_low_before", bus.Mem_WE, 1'b0);
    #1 Reset = 1'b0;
    #1;
    chk("abort_we", bus.Mem_WE, 1'b1);
    chk("abort_ce", bus.Mem_CE, 1'b1);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_hex", bus.hex_data, 16'h0);
    chk("abort_done", bus.done, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_no_partial_write", sram_peek(8'h50), 16'hA550);
    do_req(1'b1, 1'b0, 16'h0050, 16'h0000, 0, lat);
    chk("abort_readback", bus.rdata, 16'hA550);
    chk("abort_readback_latency", lat, 4);

    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
